// File: rtl/ili9341_pkg.sv
// ILI9341 shared definitions: command opcodes, window-writer state encoding, span helper.
// Also used by the init sequencer.
package ili9341_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [3:0] {
    WIN_IDLE,
    WIN_CASET_CMD,
    WIN_CASET_P,
    WIN_PASET_CMD,
    WIN_PASET_P,
    WIN_RAMWR_CMD,
    WIN_PIX_HI,
    WIN_PIX_LO,
    WIN_FINISH
  } winStateType;

  // Inclusive span length; one bit wider than the coordinates so a full axis cannot wrap.
  function automatic logic [9:0] spanLen(input logic [8:0] lo, input logic [8:0] hi);
    return {1'b0, hi} - {1'b0, lo} + 10'd1;
  endfunction

endpackage

// File: rtl/ili9341_byte_sender.sv
// One-byte Wishbone-style handshake toward the SPI master, including D/C timing.
// A byte is only launched while the strobe is low and the master is not busy.
module ili9341_byte_sender (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       send,
  input  logic [7:0] sendByte,
  input  logic       sendDc,
  output logic       ready,
  output logic       done,
  input  logic       spiAck,
  input  logic       spiBusy,
  output logic       spiStb,
  output logic [7:0] spiDat,
  output logic       tftDc
);

  assign ready = !spiStb && !spiBusy;
  assign done  = spiStb && spiAck;

  // Strobe drops the edge after ACK, which guarantees one idle cycle between bytes.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      spiStb <= 1'b0;
      spiDat <= 8'h00;
      tftDc  <= 1'b1;
    end else if (done) begin
      spiStb <= 1'b0;
    end else if (send && ready) begin
      spiStb <= 1'b1;
      spiDat <= sendByte;
      tftDc  <= sendDc;
    end
  end

endmodule

// File: rtl/ili9341_window_writer.sv
// Sends CASET/PASET/RAMWR for one window, then streams RGB565 pixels MSB byte first.
//
// state          | meaning
// WIN_IDLE       | waiting for a window request (ready when initDone)
// WIN_CASET_CMD  | sending 0x2A with D/C low
// WIN_CASET_P    | sending X0hi, X0lo, X1hi, X1lo
// WIN_PASET_CMD  | sending 0x2B with D/C low
// WIN_PASET_P    | sending Y0hi, Y0lo, Y1hi, Y1lo
// WIN_RAMWR_CMD  | sending 0x2C with D/C low
// WIN_PIX_HI     | waiting for a pixel, sending its high byte
// WIN_PIX_LO     | sending the latched low byte, counting down
// WIN_FINISH     | winDone pulse, back to idle
module ili9341_window_writer
  import ili9341_pkg::*;
#(
  parameter int MAX_X = 240,
  parameter int MAX_Y = 320,
  parameter int CNT_W = 17
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       initDone,
  input  logic       winValid,
  output logic       winReady,
  input  logic [7:0] winX0,
  input  logic [7:0] winX1,
  input  logic [8:0] winY0,
  input  logic [8:0] winY1,
  input  logic       pixValid,
  input  logic [15:0] pixData,
  output logic       pixReady,
  output logic       winDone,
  output logic       winErr,
  output logic       spiStb,
  output logic [7:0] spiAdr,
  output logic [7:0] spiDat,
  input  logic       spiAck,
  input  logic       spiBusy,
  output logic       tftDc
);

  winStateType      state, stateNext;
  logic [1:0]       paramIdx;
  logic [7:0]       xS, xE;
  logic [8:0]       yS, yE;
  logic [7:0]       pixLo;
  logic [CNT_W-1:0] pixCnt, cntLoad, cntDec;
  logic             winBad, acceptOk, rejectReq;
  logic             send, sendDc, sendReady, byteDone;
  logic [7:0]       sendByte;

  assign spiAdr    = 8'h00;
  assign winReady  = (state == WIN_IDLE) && initDone;
  assign winBad    = (winX0 > winX1) || (winY0 > winY1) ||
                     (int'(winX1) >= MAX_X) || (int'(winY1) >= MAX_Y);
  assign acceptOk  = winValid && winReady && !winBad;
  assign rejectReq = winValid && winReady && winBad;
  assign cntLoad   = CNT_W'(spanLen({1'b0, winX0}, {1'b0, winX1})) *
                     CNT_W'(spanLen(winY0, winY1));
  assign cntDec    = pixCnt - CNT_W'(1);
  assign pixReady  = (state == WIN_PIX_HI) && pixValid && sendReady;
  assign winDone   = (state == WIN_FINISH);

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state    <= WIN_IDLE;
      paramIdx <= 2'd0;
      xS       <= 8'h00;
      xE       <= 8'h00;
      yS       <= 9'h000;
      yE       <= 9'h000;
      pixLo    <= 8'h00;
      pixCnt   <= '0;
      winErr   <= 1'b0;
    end else begin
      state  <= stateNext;
      winErr <= rejectReq;
      if (acceptOk) begin
        xS     <= winX0;
        xE     <= winX1;
        yS     <= winY0;
        yE     <= winY1;
        pixCnt <= cntLoad;
      end
      if (pixReady) pixLo <= pixData[7:0];
      if (byteDone && (state == WIN_CASET_P || state == WIN_PASET_P))
        paramIdx <= paramIdx + 2'd1;
      if (byteDone && state == WIN_PIX_LO) pixCnt <= cntDec;
    end
  end

  always_comb begin
    stateNext = state;
    send      = 1'b0;
    sendDc    = 1'b1;
    sendByte  = 8'h00;
    unique case (state)
      WIN_IDLE: if (acceptOk) stateNext = WIN_CASET_CMD;
      WIN_CASET_CMD: begin
        send     = 1'b1;
        sendDc   = 1'b0;
        sendByte = CMD_CASET;
        if (byteDone) stateNext = WIN_CASET_P;
      end
      WIN_CASET_P: begin
        send = 1'b1;
        case (paramIdx)
          2'd1:    sendByte = xS;
          2'd3:    sendByte = xE;
          default: sendByte = 8'h00;
        endcase
        if (byteDone && paramIdx == 2'd3) stateNext = WIN_PASET_CMD;
      end
      WIN_PASET_CMD: begin
        send     = 1'b1;
        sendDc   = 1'b0;
        sendByte = CMD_PASET;
        if (byteDone) stateNext = WIN_PASET_P;
      end
      WIN_PASET_P: begin
        send = 1'b1;
        case (paramIdx)
          2'd0:    sendByte = {7'b0, yS[8]};
          2'd1:    sendByte = yS[7:0];
          2'd2:    sendByte = {7'b0, yE[8]};
          default: sendByte = yE[7:0];
        endcase
        if (byteDone && paramIdx == 2'd3) stateNext = WIN_RAMWR_CMD;
      end
      WIN_RAMWR_CMD: begin
        send     = 1'b1;
        sendDc   = 1'b0;
        sendByte = CMD_RAMWR;
        if (byteDone) stateNext = WIN_PIX_HI;
      end
      WIN_PIX_HI: begin
        send     = pixValid;
        sendByte = pixData[15:8];
        if (byteDone) stateNext = WIN_PIX_LO;
      end
      WIN_PIX_LO: begin
        send     = 1'b1;
        sendByte = pixLo;
        if (byteDone) stateNext = (cntDec == '0) ? WIN_FINISH : WIN_PIX_HI;
      end
      WIN_FINISH: stateNext = WIN_IDLE;
      default:    stateNext = WIN_IDLE;
    endcase
  end

  ili9341_byte_sender uSender (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .send     (send),
    .sendByte (sendByte),
    .sendDc   (sendDc),
    .ready    (sendReady),
    .done     (byteDone),
    .spiAck   (spiAck),
    .spiBusy  (spiBusy),
    .spiStb   (spiStb),
    .spiDat   (spiDat),
    .tftDc    (tftDc)
  );

endmodule
